// File: rtl/vending_machine_seq.sv
// vending_machine_seq
// Accumulates nickel/dime/quarter credit up to a compile-time price, pulses a
// one-cycle vend strobe, then pays out change (or a full refund on cancel) one
// coin per hopper handshake, largest denomination first.
//
// Parameter constraints: PRICE is a multiple of 5 and >= 5; 2**CW > PRICE + 20.
// Within those bounds credit is always a multiple of 5 and never exceeds
// PRICE + 20, so the unsigned CW-bit arithmetic below cannot wrap.

module vending_machine_seq #(
  parameter int unsigned PRICE = 20,
  parameter int unsigned CW    = 7
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_nickel,
  input  logic          i_dime,
  input  logic          i_quarter,
  input  logic          i_cancel,
  input  logic          i_chg_ready,
  output logic          o_vend,
  output logic [CW-1:0] o_credit,
  output logic          o_chg_valid,
  output logic [1:0]    o_chg_coin,
  output logic          o_coin_reject,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_e;

  // Coin encodings on o_chg_coin.
  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  // Coin values and price at credit-register width.
  localparam logic [CW-1:0] VAL_NICKEL  = CW'(5);
  localparam logic [CW-1:0] VAL_DIME    = CW'(10);
  localparam logic [CW-1:0] VAL_QUARTER = CW'(25);
  localparam logic [CW-1:0] PRICE_C     = CW'(PRICE);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          reject_q, reject_d;

  logic [2:0]    coins;
  logic          any_coin;
  logic [CW-1:0] add_val;
  logic          add_ok;
  logic [CW-1:0] credit_sum;
  logic [1:0]    chg_coin;
  logic [CW-1:0] chg_val;

  assign coins    = {i_quarter, i_dime, i_nickel};
  assign any_coin = |coins;

  // Decode a single inserted coin; add_ok is low for none or for a collision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    add_val = '0;
    add_ok  = 1'b0;
    unique case (coins)
      3'b001:  begin add_val = VAL_NICKEL;  add_ok = 1'b1; end
      3'b010:  begin add_val = VAL_DIME;    add_ok = 1'b1; end
      3'b100:  begin add_val = VAL_QUARTER; add_ok = 1'b1; end
      default: begin add_val = '0;          add_ok = 1'b0; end
    endcase
  end

  assign credit_sum = credit_q + add_val;

  // Greedy change selection from the registered credit: quarter, dime, nickel.
  always_comb begin
    chg_coin = COIN_NICKEL;
    chg_val  = VAL_NICKEL;
    if (credit_q >= VAL_QUARTER) begin
      chg_coin = COIN_QUARTER;
      chg_val  = VAL_QUARTER;
    end else if (credit_q >= VAL_DIME) begin
      chg_coin = COIN_DIME;
      chg_val  = VAL_DIME;
    end
  end

  // Next-state, next-credit and coin-reject decision.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        if (i_cancel) begin
          // Cancel wins over any coin seen in the same cycle.
          reject_d = any_coin;
          if (credit_q != '0) begin
            state_d = ST_CHANGE;
          end
        end else if (add_ok) begin
          credit_d = credit_sum;
          if (credit_sum >= PRICE_C) begin
            state_d = ST_VEND;
          end
        end else begin
          // Two or three coins at once cannot be credited reliably.
          reject_d = any_coin;
        end
      end

      ST_VEND: begin
        reject_d = any_coin;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q == PRICE_C) ? ST_COLLECT : ST_CHANGE;
      end

      ST_CHANGE: begin
        reject_d = any_coin;
        if (i_chg_ready) begin
          credit_d = credit_q - chg_val;
          if (credit_q == chg_val) begin
            state_d = ST_COLLECT;
          end
        end
      end

      default: begin
        state_d  = ST_COLLECT;
        credit_d = '0;
      end
    endcase
  end

  // State, credit and reject-pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_COLLECT;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from
      // pre-edge values; blocking here would create order-dependent races.
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Outputs are decoded from registered state only.
  assign o_vend        = (state_q == ST_VEND);
  assign o_busy        = (state_q != ST_COLLECT);
  assign o_chg_valid   = (state_q == ST_CHANGE);
  assign o_chg_coin    = o_chg_valid ? chg_coin : COIN_NONE;
  assign o_credit      = credit_q;
  assign o_coin_reject = reject_q;

endmodule

// File: tb/tb_vending_machine_seq.sv
// Directed testbench for vending_machine_seq at PRICE=20, CW=7.
// Inputs change on the falling edge; outputs are checked on the falling edge
// that follows each rising edge.

module tb_vending_machine_seq;

  localparam int unsigned PRICE = 20;
  localparam int unsigned CW    = 7;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_nickel;
  logic          i_dime;
  logic          i_quarter;
  logic          i_cancel;
  logic          i_chg_ready;
  logic          o_vend;
  logic [CW-1:0] o_credit;
  logic          o_chg_valid;
  logic [1:0]    o_chg_coin;
  logic          o_coin_reject;
  logic          o_busy;

  int n_checks;
  int n_fail;

  vending_machine_seq #(.PRICE(PRICE), .CW(CW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_nickel      (i_nickel),
    .i_dime        (i_dime),
    .i_quarter     (i_quarter),
    .i_cancel      (i_cancel),
    .i_chg_ready   (i_chg_ready),
    .o_vend        (o_vend),
    .o_credit      (o_credit),
    .o_chg_valid   (o_chg_valid),
    .o_chg_coin    (o_chg_coin),
    .o_coin_reject (o_coin_reject),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Apply {cancel, quarter, dime, nickel} for one rising edge, starting at a
  // falling edge; returns at the next falling edge with inputs cleared.
  task automatic cycle(input logic [3:0] in);
    i_cancel  = in[3];
    i_quarter = in[2];
    i_dime    = in[1];
    i_nickel  = in[0];
    @(negedge i_clk);
    i_cancel  = 1'b0;
    i_quarter = 1'b0;
    i_dime    = 1'b0;
    i_nickel  = 1'b0;
  endtask

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] NIC  = 4'b0001;
  localparam logic [3:0] DIM  = 4'b0010;
  localparam logic [3:0] QTR  = 4'b0100;
  localparam logic [3:0] CAN  = 4'b1000;

  task automatic test_reset;
    i_rst_n     = 1'b0;
    i_nickel    = 1'b0;
    i_dime      = 1'b0;
    i_quarter   = 1'b0;
    i_cancel    = 1'b0;
    i_chg_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_vend, o_credit, o_chg_valid, o_chg_coin, o_coin_reject, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vend=%b credit=%0d valid=%b coin=%b rej=%b busy=%b want all 0",
               o_vend, o_credit, o_chg_valid, o_chg_coin, o_coin_reject, o_busy);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_vend, o_credit, o_chg_valid, o_chg_coin, o_coin_reject, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got vend=%b credit=%0d busy=%b want all 0",
               o_vend, o_credit, o_busy);
    end
  endtask

  task automatic test_single_quarter;
    i_chg_ready = 1'b1;
    cycle(QTR);
    n_checks++;
    if (o_credit !== 7'd25 || o_vend !== 1'b1 || o_busy !== 1'b1 || o_chg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL quarter_vend: got credit=%0d vend=%b busy=%b valid=%b want 25 1 1 0",
               o_credit, o_vend, o_busy, o_chg_valid);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd5 || o_chg_valid !== 1'b1 || o_chg_coin !== 2'b01 || o_vend !== 1'b0) begin
      n_fail++;
      $display("FAIL quarter_change: got credit=%0d valid=%b coin=%b vend=%b want 5 1 01 0",
               o_credit, o_chg_valid, o_chg_coin, o_vend);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd0 || o_chg_valid !== 1'b0 || o_chg_coin !== 2'b00 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL quarter_done: got credit=%0d valid=%b coin=%b busy=%b want 0 0 00 0",
               o_credit, o_chg_valid, o_chg_coin, o_busy);
    end
  endtask

  task automatic test_two_dimes;
    i_chg_ready = 1'b1;
    cycle(DIM);
    n_checks++;
    if (o_credit !== 7'd10 || o_vend !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dime1: got credit=%0d vend=%b busy=%b want 10 0 0", o_credit, o_vend, o_busy);
    end
    cycle(DIM);
    n_checks++;
    if (o_credit !== 7'd20 || o_vend !== 1'b1) begin
      n_fail++;
      $display("FAIL dime2_vend: got credit=%0d vend=%b want 20 1", o_credit, o_vend);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd0 || o_vend !== 1'b0 || o_chg_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dimes_done: got credit=%0d vend=%b valid=%b busy=%b want 0 0 0 0",
               o_credit, o_vend, o_chg_valid, o_busy);
    end
  endtask

  task automatic test_cancel_stall;
    i_chg_ready = 1'b0;
    cycle(DIM);
    cycle(NIC);
    n_checks++;
    if (o_credit !== 7'd15 || o_vend !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_credit: got credit=%0d vend=%b busy=%b want 15 0 0", o_credit, o_vend, o_busy);
    end
    cycle(CAN);
    n_checks++;
    if (o_chg_valid !== 1'b1 || o_chg_coin !== 2'b10 || o_credit !== 7'd15 || o_coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_present: got valid=%b coin=%b credit=%0d rej=%b want 1 10 15 0",
               o_chg_valid, o_chg_coin, o_credit, o_coin_reject);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(NONE);
      n_checks++;
      if (o_chg_valid !== 1'b1 || o_chg_coin !== 2'b10 || o_credit !== 7'd15 || o_vend !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b coin=%b credit=%0d vend=%b want 1 10 15 0",
                 i, o_chg_valid, o_chg_coin, o_credit, o_vend);
      end
    end
    i_chg_ready = 1'b1;
    cycle(NONE);
    n_checks++;
    if (o_chg_valid !== 1'b1 || o_chg_coin !== 2'b01 || o_credit !== 7'd5 || o_vend !== 1'b0) begin
      n_fail++;
      $display("FAIL refund_nickel: got valid=%b coin=%b credit=%0d vend=%b want 1 01 5 0",
               o_chg_valid, o_chg_coin, o_credit, o_vend);
    end
    cycle(NONE);
    n_checks++;
    if (o_chg_valid !== 1'b0 || o_credit !== 7'd0 || o_busy !== 1'b0 || o_vend !== 1'b0) begin
      n_fail++;
      $display("FAIL refund_done: got valid=%b credit=%0d busy=%b vend=%b want 0 0 0 0",
               o_chg_valid, o_credit, o_busy, o_vend);
    end
  endtask

  task automatic test_reject;
    i_chg_ready = 1'b1;
    cycle(DIM | QTR);
    n_checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 7'd0) begin
      n_fail++;
      $display("FAIL multi_coin: got rej=%b credit=%0d want 1 0", o_coin_reject, o_credit);
    end
    cycle(NONE);
    n_checks++;
    if (o_coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_one_cycle: got rej=%b want 0", o_coin_reject);
    end
    // Cancel with zero credit: coin rejected, cancel ignored.
    cycle(CAN | NIC);
    n_checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 7'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_coin_zero: got rej=%b credit=%0d busy=%b want 1 0 0",
               o_coin_reject, o_credit, o_busy);
    end
    cycle(QTR);
    n_checks++;
    if (o_vend !== 1'b1 || o_credit !== 7'd25 || o_coin_reject !== 1'b0) begin
      n_fail++;
      $display("FAIL rej_setup_vend: got vend=%b credit=%0d rej=%b want 1 25 0", o_vend, o_credit, o_coin_reject);
    end
    // Quarter (and a cancel) while vending: rejected, cancel ignored.
    cycle(QTR | CAN);
    n_checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 7'd5 || o_chg_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL coin_in_vend: got rej=%b credit=%0d valid=%b want 1 5 1",
               o_coin_reject, o_credit, o_chg_valid);
    end
    cycle(QTR);
    n_checks++;
    if (o_coin_reject !== 1'b1 || o_credit !== 7'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL coin_in_change: got rej=%b credit=%0d busy=%b want 1 0 0",
               o_coin_reject, o_credit, o_busy);
    end
    cycle(NONE);
    n_checks++;
    if (o_coin_reject !== 1'b0 || o_credit !== 7'd0) begin
      n_fail++;
      $display("FAIL reject_clear: got rej=%b credit=%0d want 0 0", o_coin_reject, o_credit);
    end
  endtask

  task automatic test_nickel_quarter;
    i_chg_ready = 1'b1;
    cycle(NIC);
    cycle(QTR);
    n_checks++;
    if (o_credit !== 7'd30 || o_vend !== 1'b1) begin
      n_fail++;
      $display("FAIL nq_vend: got credit=%0d vend=%b want 30 1", o_credit, o_vend);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd10 || o_chg_valid !== 1'b1 || o_chg_coin !== 2'b10) begin
      n_fail++;
      $display("FAIL nq_change: got credit=%0d valid=%b coin=%b want 10 1 10",
               o_credit, o_chg_valid, o_chg_coin);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd0 || o_chg_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nq_done: got credit=%0d valid=%b busy=%b want 0 0 0", o_credit, o_chg_valid, o_busy);
    end
  endtask

  task automatic test_back_to_back;
    i_chg_ready = 1'b1;
    cycle(QTR);   // -> VEND, 25
    cycle(NONE);  // -> CHANGE, 5 (nickel presented, ready high)
    cycle(NONE);  // handshake -> COLLECT, 0
    // First cycle back in COLLECT: this dime must be credited.
    cycle(DIM);
    n_checks++;
    if (o_credit !== 7'd10 || o_coin_reject !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got credit=%0d rej=%b busy=%b want 10 0 0", o_credit, o_coin_reject, o_busy);
    end
    cycle(CAN);
    n_checks++;
    if (o_chg_coin !== 2'b10 || o_credit !== 7'd10) begin
      n_fail++;
      $display("FAIL b2b_refund: got coin=%b credit=%0d want 10 10", o_chg_coin, o_credit);
    end
    cycle(NONE);
    n_checks++;
    if (o_credit !== 7'd0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got credit=%0d busy=%b want 0 0", o_credit, o_busy);
    end
  endtask

  task automatic test_reset_mid_change;
    i_chg_ready = 1'b0;
    cycle(NIC);
    cycle(DIM);
    cycle(CAN);
    n_checks++;
    if (o_chg_valid !== 1'b1 || o_credit !== 7'd15) begin
      n_fail++;
      $display("FAIL rst_setup: got valid=%b credit=%0d want 1 15", o_chg_valid, o_credit);
    end
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_vend, o_credit, o_chg_valid, o_chg_coin, o_coin_reject, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b coin=%b credit=%0d busy=%b want all 0",
               o_chg_valid, o_chg_coin, o_credit, o_busy);
    end
    #1;
    i_rst_n     = 1'b1;
    i_chg_ready = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_credit !== 7'd0 || o_busy !== 1'b0 || o_chg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset: got credit=%0d busy=%b valid=%b want 0 0 0", o_credit, o_busy, o_chg_valid);
    end
    cycle(NIC);
    n_checks++;
    if (o_credit !== 7'd5 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_coin: got credit=%0d busy=%b want 5 0", o_credit, o_busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_quarter();
    test_two_dimes();
    test_cancel_stall();
    test_reject();
    test_nickel_quarter();
    test_back_to_back();
    test_reset_mid_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
